// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control bundle between the multicycle controller and its datapath
// Purpose: groups instruction fields, memory handshake, datapath selects/enables and status.
// Ports (master = controller side):
//   in : op[6:0], funct3[2:0], funct7b5, zero, mem_ready
//   out: mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite, resultsrc[1:0],
//        alusrca[1:0], alusrcb[1:0], immsrc[1:0], alucontrol[2:0], retire,
//        instret[CNT_W-1:0], illegal
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             adrsrc;
    logic             irwrite;
    logic             pcwrite;
    logic             memwrite;
    logic             regwrite;
    logic [1:0]       resultsrc;
    logic [1:0]       alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       immsrc;
    logic [2:0]       alucontrol;
    logic             retire;
    logic [CNT_W-1:0] instret;
    logic             illegal;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite,
               resultsrc, alusrca, alusrcb, immsrc, alucontrol,
               retire, instret, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite,
               resultsrc, alusrca, alusrcb, immsrc, alucontrol,
               retire, instret, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing a shared-ALU multicycle RV32I-subset datapath
// Purpose: drives datapath selects/enables for lw, sw, R-type, I-type ALU, jal and beq,
//          decodes ALU control, waits on memory, counts retirements, traps unsupported opcodes.
// Ports: clk (rising edge), rst_n (async active-low),
//        bus (multicycle_controller_if.master): instruction fields and memory handshake in,
//        datapath control, retire pulse, instret counter and sticky illegal flag out.
module multicycle_controller #(
    parameter int USE_MEM_READY = 1,
    parameter int CNT_W         = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    multicycle_controller_if.master       bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_JAL, S_ALUWB, S_BEQ, S_ILLEGAL
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;
    logic             r_illegal;

    logic       w_rdy;
    logic       w_f3_alu_ok;
    logic [1:0] w_aluop;
    logic       w_mem_req, w_adrsrc, w_irwrite, w_pcwrite, w_memwrite, w_regwrite, w_retire;
    logic [1:0] w_resultsrc, w_alusrca, w_alusrcb;

    assign w_rdy = (USE_MEM_READY != 0) ? bus.mem_ready : 1'b1;

    // R/I-type ALU ops implemented: add/sub, slt, or, and.
    assign w_f3_alu_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b010) ||
                         (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);

    always_comb begin
        w_next      = r_state;
        w_aluop     = 2'b00;
        w_mem_req   = 1'b0;
        w_adrsrc    = 1'b0;
        w_irwrite   = 1'b0;
        w_pcwrite   = 1'b0;
        w_memwrite  = 1'b0;
        w_regwrite  = 1'b0;
        w_retire    = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_irwrite   = w_rdy;
                w_pcwrite   = w_rdy;
                if (w_rdy) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
                case (bus.op)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011: w_next = w_f3_alu_ok ? S_EXECR : S_ILLEGAL;
                    7'b0010011: w_next = w_f3_alu_ok ? S_EXECI : S_ILLEGAL;
                    7'b1101111: w_next = S_JAL;
                    7'b1100011: w_next = (bus.funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
                    default:    w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_next    = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adrsrc  = 1'b1;
                if (w_rdy) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe is held for the whole access; the store retires in its completing cycle.
                w_mem_req  = 1'b1;
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
                w_retire   = w_rdy;
                if (w_rdy) w_next = S_FETCH;
            end
            S_EXECR: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_JAL: begin
                // ALU computes oldPC+4 for the link value while PC takes the jump target.
                w_alusrca = 2'b01;
                w_alusrcb = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQ: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b01;
                w_pcwrite = bus.zero;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_ILLEGAL: w_next = S_ILLEGAL;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        bus.alucontrol = 3'b000;
        case (w_aluop)
            2'b01: bus.alucontrol = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  bus.alucontrol = (bus.op[5] && bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  bus.alucontrol = 3'b101;
                    3'b110:  bus.alucontrol = 3'b011;
                    3'b111:  bus.alucontrol = 3'b010;
                    default: bus.alucontrol = 3'b000;
                endcase
            end
            default: bus.alucontrol = 3'b000;
        endcase
    end

    always_comb begin
        case (bus.op)
            7'b0000011, 7'b0010011: bus.immsrc = 2'b00;
            7'b0100011:             bus.immsrc = 2'b01;
            7'b1100011:             bus.immsrc = 2'b10;
            7'b1101111:             bus.immsrc = 2'b11;
            default:                bus.immsrc = 2'b00;
        endcase
    end

    // Strobes are gated by rst_n so nothing can fire between rst_n falling and the next edge.
    assign bus.mem_req   = w_mem_req  & rst_n;
    assign bus.irwrite   = w_irwrite  & rst_n;
    assign bus.pcwrite   = w_pcwrite  & rst_n;
    assign bus.memwrite  = w_memwrite & rst_n;
    assign bus.regwrite  = w_regwrite & rst_n;
    assign bus.retire    = w_retire   & rst_n;
    assign bus.adrsrc    = w_adrsrc;
    assign bus.resultsrc = w_resultsrc;
    assign bus.alusrca   = w_alusrca;
    assign bus.alusrcb   = w_alusrcb;
    assign bus.instret   = r_instret;
    assign bus.illegal   = r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
            if (r_state == S_ILLEGAL) r_illegal <= 1'b1;
        end
    end
endmodule
